buck_pwm_ctrl: RTL
==================

Name: buck_pwm_ctrl

Overview:
Digital PWM controller that drives the gate input of the buck power-stage model. It replaces the fixed-duty PWM macro with a sequenced controller that provides:
- a period counter,
- a shadowed duty register,
- soft-start ramping,
- cycle-by-cycle over-current protection with timed auto-retry.
It sits between testbench/control logic and the buck model's gate port. It consumes a quantized inductor-current code derived from i_mag.

Parameters:
PERIOD, 200, PWM period in clk cycles (500 kHz at 10 ns DT)
CNT_W, 8, width of period counter and duty quantities; must hold PERIOD
I_W, 16, width of signed current code
OC_LIMIT, 16'sd12000, signed over-current trip threshold in current-code LSBs
SS_STEP, 1, duty increment (counts) per period during soft-start
RETRY_PERIODS, 4, full periods spent in FAULT before a retry

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  converter enable
duty_cmd  input  CNT_W  commanded on-time in clk cycles per period
i_mag_code  input  I_W  signed inductor-current code
gate  output  1  high-side gate drive to buck model
period_start  output  1  one-cycle pulse at cnt==0 while running
state  output  2  0=IDLE 1=SOFTSTART 2=RUN 3=FAULT
fault  output  1  high while in FAULT
duty_active  output  CNT_W  duty currently applied

Behaviour:
- Reset: all outputs and internal registers go to 0. state=IDLE, cnt=0, retry count=0.
- cnt_clip = min(duty_cmd, PERIOD).
- Period counter cnt: counts 0..PERIOD-1 and wraps to 0. It advances in SOFTSTART, RUN and FAULT, and is held at 0 in IDLE.
- period_start is registered, and is 1 in exactly the cycles where cnt==0 and state!=IDLE.
- gate is registered and computed from next-state values. For each cycle, gate==1 iff state∈{SOFTSTART,RUN} and cnt<duty_active, both read in that same cycle.
- duty_active changes only at the period boundary (cycle where cnt==PERIOD-1 → next cnt==0). A mid-period change of duty_cmd never alters the current period.
- IDLE:
  - en=1 → SOFTSTART next cycle, with cnt=0 and duty_active=0.
- SOFTSTART:
  - At each boundary, duty_active ← min(duty_active+SS_STEP, cnt_clip).
  - If the new value equals cnt_clip → RUN on that boundary.
  - If duty_cmd drops below the current duty_active, duty_active ← cnt_clip at the boundary and the state goes to RUN.
- RUN:
  - At each boundary, duty_active ← cnt_clip.
- Over-current (SOFTSTART or RUN):
  - Trip condition: i_mag_code > OC_LIMIT (signed compare), sampled every cycle.
  - Next cycle: state=FAULT, gate=0, fault=1, duty_active=0, cnt=0, retry count=0. Trip latency is 1 cycle.
- FAULT:
  - gate is held 0.
  - The retry count increments at each wrap.
  - When the count reaches RETRY_PERIODS at a wrap:
    - if i_mag_code <= OC_LIMIT → SOFTSTART (fault=0, duty ramps from 0);
    - otherwise the retry count clears and the wait restarts.
- en=0 in any state → IDLE next cycle with gate=0, cnt=0, duty_active=0, fault=0. en=0 has priority over over-current and over the boundary update.
- duty_cmd=0: gate never asserts. SOFTSTART → RUN at the first boundary.
- duty_cmd>=PERIOD: gate stays high across the wrap once duty_active==PERIOD, i.e. 100% duty with no dropout cycle.
- A trip coinciding with a boundary takes priority over the duty update.
- Asserting rst mid-operation returns to the reset state immediately, with gate=0 asynchronously.

Test Plan:
- Reset then en=1, duty_cmd=100, SS_STEP=1 → duty_active=1,2,...,100 over 100 periods. state=RUN from the boundary where duty_active reaches 100. Afterwards gate is high exactly 100 of every 200 cycles and period_start fires every 200 cycles.
- In RUN at duty 100, change duty_cmd to 40 at cnt=50 → the current period keeps 100 high cycles. The next period has 40 high cycles, aligned with cnt=0.
- In RUN, drive i_mag_code=12001 for one cycle at cnt=20 → gate=0 and state=FAULT the next cycle. Then gate=0 for 4×200 cycles, SOFTSTART re-entered, and duty ramps from 1.
- Hold i_mag_code=13000 through FAULT → state stays FAULT past 800 cycles. Release it to 0 → SOFTSTART at the next 4-period boundary.
- duty_cmd=255 (>PERIOD) → duty_active saturates at 200 and gate is continuously high in RUN. duty_cmd=0 → gate never high and RUN reached at the first boundary.
- en=0 coincident with an over-current trip → IDLE with fault=0. Asserting rst at cnt=57 in RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/buck_pwm_ctrl.sv
// Sequenced PWM gate controller for the buck power stage: period counter,
// boundary-shadowed duty, soft-start ramp and over-current fault with timed retry.
module buck_pwm_ctrl #(
  parameter int                      PERIOD        = 200,
  parameter int                      CNT_W         = 8,
  parameter int                      I_W           = 16,
  parameter logic signed [I_W-1:0]   OC_LIMIT      = 16'sd12000,
  parameter int                      SS_STEP       = 1,
  parameter int                      RETRY_PERIODS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CNT_W-1:0]      duty_cmd,
  input  logic signed [I_W-1:0] i_mag_code,
  output logic                  gate,
  output logic                  period_start,
  output logic [1:0]            state,
  output logic                  fault,
  output logic [CNT_W-1:0]      duty_active
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SOFTSTART = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_e;

  localparam int               RET_W    = $clog2(RETRY_PERIODS + 1);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W:0]   STEP_C   = (CNT_W + 1)'(SS_STEP);
  localparam logic [RET_W-1:0] RET_LAST = RET_W'(RETRY_PERIODS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [RET_W-1:0] retry_q, retry_d;
  logic             gate_q, gate_d;
  logic             ps_q, ps_d;
  logic             fault_q, fault_d;

  logic [CNT_W-1:0] cnt_clip;
  logic [CNT_W-1:0] cnt_adv;
  logic [CNT_W:0]   ramp_sum;
  logic [CNT_W-1:0] ramp_val;
  logic             at_wrap;
  logic             oc_trip;

  always_comb begin
    cnt_clip = (duty_cmd > PERIOD_C) ? PERIOD_C : duty_cmd;
    at_wrap  = (cnt_q == LAST_C);
    cnt_adv  = at_wrap ? '0 : cnt_q + 1'b1;
    oc_trip  = (i_mag_code > OC_LIMIT);
    ramp_sum = {1'b0, duty_q} + STEP_C;
    ramp_val = (ramp_sum > {1'b0, cnt_clip}) ? cnt_clip : ramp_sum[CNT_W-1:0];

    state_d = state_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    retry_d = retry_q;

    // Disable outranks both the trip and the boundary duty update.
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      duty_d  = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SOFTSTART;
          cnt_d   = '0;
          duty_d  = '0;
          retry_d = '0;
        end
        ST_SOFTSTART, ST_RUN: begin
          if (oc_trip) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
            duty_d  = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_adv;
            if (at_wrap) begin
              if (state_q == ST_RUN || duty_cmd < duty_q) begin
                duty_d  = cnt_clip;
                state_d = ST_RUN;
              end else begin
                duty_d = ramp_val;
                if (ramp_val == cnt_clip) state_d = ST_RUN;
              end
            end
          end
        end
        ST_FAULT: begin
          cnt_d = cnt_adv;
          if (at_wrap) begin
            if (retry_q == RET_LAST) begin
              retry_d = '0;
              if (!oc_trip) begin
                state_d = ST_SOFTSTART;
                duty_d  = '0;
              end
            end else begin
              retry_d = retry_q + 1'b1;
            end
          end
        end
      endcase
    end

    // Outputs are derived from next-state values so they line up with cnt/duty.
    gate_d  = (state_d == ST_SOFTSTART || state_d == ST_RUN) && (cnt_d < duty_d);
    ps_d    = (cnt_d == '0) && (state_d != ST_IDLE);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      retry_q <= '0;
      gate_q  <= 1'b0;
      ps_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      retry_q <= retry_d;
      gate_q  <= gate_d;
      ps_q    <= ps_d;
      fault_q <= fault_d;
    end
  end

  assign gate         = gate_q;
  assign period_start = ps_q;
  assign state        = state_q;
  assign fault        = fault_q;
  assign duty_active  = duty_q;

endmodule
